holy_csr_unit: RTL and testbench

- Second-generation machine-mode CSR unit for the HOLY CORE. Replaces the fixed single-region CSR file.
- Adds a parametrised count of non-cachable regions, vectored mtvec, mscratch, and 64-bit mcycle/minstret with mcountinhibit.
- Adds fixed-priority interrupt encoding and illegal-CSR-access detection.
- Sits beside control/decode; drives trap redirection and cache policy.

---
 rtl/holy_csr_pkg.sv | 59 +++++
 rtl/holy_csr_if.sv | 14 +
 rtl/holy_csr_counter64.sv | 38 +++
 rtl/holy_csr_unit.sv | 190 +++++++++++++++++++
 tb/tb_holy_csr_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/holy_csr_pkg.sv
// Shared definitions for the HOLY CORE machine-mode CSR unit: CSR map,
// interrupt cause codes, operation encodings and small helpers.
package holy_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_FLUSH         = 12'h7C0;
  localparam logic [11:0] CSR_NC_BASE0      = 12'h7C1;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MCINH_WMASK   = 32'h0000_0005;

  localparam logic [30:0] IRQ_SOFT  = 31'd3;
  localparam logic [30:0] IRQ_TIMER = 31'd7;
  localparam logic [30:0] IRQ_EXT   = 31'd11;

  typedef enum logic [1:0] {
    DIRECT   = 2'b00,
    VECTORED = 2'b01
  } mtvec_mode_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] cur,
                                            input logic [31:0] wd);
    case (op)
      OP_WRITE: return wd;
      OP_SET:   return cur | wd;
      OP_CLEAR: return cur & ~wd;
      default:  return cur;
    endcase
  endfunction

  // Region i: base at 0x7C1+2i, limit right after it.
  function automatic logic [11:0] nc_addr(input int idx, input logic is_limit);
    return CSR_NC_BASE0 + 12'(2 * idx) + {11'h000, is_limit};
  endfunction

endpackage

// File: rtl/holy_csr_if.sv
// CSR access bus between decode/control (master) and the CSR unit (slave).
interface holy_csr_if;
  logic [2:0]  f3;
  logic [31:0] write_data;
  logic        write_enable;
  logic [11:0] address;
  logic [31:0] read_data;
  logic        illegal_access;

  modport master (output f3, write_data, write_enable, address,
                  input  read_data, illegal_access);
  modport slave  (input  f3, write_data, write_enable, address,
                  output read_data, illegal_access);
endinterface

// File: rtl/holy_csr_counter64.sv
// 64-bit event counter with inhibit and independent half-word software writes.
module holy_csr_counter64
  import holy_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] next_s;

  // A software write replaces the increment for that cycle; no carry from it.
  always_comb begin
    next_s = value;
    if (wr_lo || wr_hi) begin
      next_s = {wr_hi ? wdata : value[63:32], wr_lo ? wdata : value[31:0]};
    end else if (inc && !inhibit) begin
      next_s = value + 64'd1;
    end else begin
      next_s = value;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= 64'd0;
    end else begin
      value <= next_s;
    end
  end

endmodule

// File: rtl/holy_csr_unit.sv
// HOLY CORE machine-mode CSR unit: CSR file, counters, interrupt/exception
// trap entry and return, non-cachable region registers and cache flush.
module holy_csr_unit
  import holy_csr_pkg::*;
#(
  parameter int NUM_NC_REGIONS = 2,
  parameter int VECTORED_EN    = 1,
  parameter int COUNTERS_EN    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  holy_csr_if.slave                   bus,
  input  logic [31:0]                 current_core_pc,
  input  logic                        instr_retired,
  input  logic                        timer_itr,
  input  logic                        soft_itr,
  input  logic                        ext_itr,
  input  logic                        m_ret,
  input  logic                        exception,
  input  logic [30:0]                 exception_cause,
  output logic                        flush_cache_flag,
  output logic [32*NUM_NC_REGIONS-1:0] nc_base,
  output logic [32*NUM_NC_REGIONS-1:0] nc_limit,
  output logic                        trap,
  output logic [31:0]                 trap_target,
  output logic [31:0]                 csr_mepc
);

  logic [31:0] mstatus_r, mie_r, mtvec_r, mcinh_r, mscratch_r, mepc_r, mcause_r, mip_r;
  logic        flush_r, trap_taken_r;
  logic [31:0] nc_base_r  [NUM_NC_REGIONS];
  logic [31:0] nc_limit_r [NUM_NC_REGIONS];
  logic [63:0] mcycle_s, minstret_s;

  logic [31:0] rdata_s, wval_s, mtvec_wr_s, vec_off_s;
  logic        mapped_s, ro_s, ctr_s, illegal_s, wr_s, irq_s, trap_s;
  logic [30:0] code_s;
  csr_op_e     op_s;
  logic        unused_s;

  assign unused_s = ^{bus.f3[2], current_core_pc[1:0]};
  assign op_s     = csr_op_e'(bus.f3[1:0]);

  // Read mux and address classification.
  always_comb begin
    rdata_s  = 32'h0;
    mapped_s = 1'b1;
    ro_s     = 1'b0;
    ctr_s    = 1'b0;
    case (bus.address)
      CSR_MSTATUS:       rdata_s = mstatus_r;
      CSR_MIE:           rdata_s = mie_r;
      CSR_MTVEC:         rdata_s = mtvec_r;
      CSR_MCOUNTINHIBIT: rdata_s = mcinh_r;
      CSR_MSCRATCH:      rdata_s = mscratch_r;
      CSR_MEPC:          rdata_s = mepc_r;
      CSR_MCAUSE:        rdata_s = mcause_r;
      CSR_MIP:           begin rdata_s = mip_r; ro_s = 1'b1; end
      CSR_FLUSH:         rdata_s = {31'h0, flush_r};
      CSR_MCYCLE:        begin rdata_s = mcycle_s[31:0];    ctr_s = 1'b1; end
      CSR_MCYCLEH:       begin rdata_s = mcycle_s[63:32];   ctr_s = 1'b1; end
      CSR_MINSTRET:      begin rdata_s = minstret_s[31:0];  ctr_s = 1'b1; end
      CSR_MINSTRETH:     begin rdata_s = minstret_s[63:32]; ctr_s = 1'b1; end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: ro_s = 1'b1;
      default: begin
        mapped_s = 1'b0;
        for (int i = 0; i < NUM_NC_REGIONS; i++) begin
          if (bus.address == nc_addr(i, 1'b0)) begin
            mapped_s = 1'b1;
            rdata_s  = nc_base_r[i];
          end else if (bus.address == nc_addr(i, 1'b1)) begin
            mapped_s = 1'b1;
            rdata_s  = nc_limit_r[i];
          end else begin
            mapped_s = mapped_s;
          end
        end
      end
    endcase
  end

  assign illegal_s = bus.write_enable &&
                     (!mapped_s || ro_s || (ctr_s && (COUNTERS_EN == 0)));
  assign wval_s    = csr_apply(op_s, rdata_s, bus.write_data);
  assign wr_s      = bus.write_enable && !illegal_s && !trap_s && (op_s != OP_NONE);

  // mtvec mode is WARL: anything but a supported vectored mode becomes direct.
  always_comb begin
    if ((wval_s[1:0] == 2'(VECTORED)) && (VECTORED_EN != 0)) begin
      mtvec_wr_s = {wval_s[31:2], 2'(VECTORED)};
    end else begin
      mtvec_wr_s = {wval_s[31:2], 2'(DIRECT)};
    end
  end

  // Trap decision, cause priority (ext > soft > timer) and vector offset.
  always_comb begin
    irq_s = (|(mie_r & mip_r)) && mstatus_r[3];
    if (irq_s) begin
      if (mie_r[11] && mip_r[11]) begin
        code_s = IRQ_EXT;
      end else if (mie_r[3] && mip_r[3]) begin
        code_s = IRQ_SOFT;
      end else begin
        code_s = IRQ_TIMER;
      end
    end else begin
      code_s = exception_cause;
    end
    trap_s = (irq_s || exception) && !trap_taken_r;
    if (irq_s && (mtvec_r[1:0] == 2'(VECTORED))) begin
      vec_off_s = {code_s[29:0], 2'b00};
    end else begin
      vec_off_s = 32'h0;
    end
  end

  // CSR state; a trap outranks both m_ret and any software write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_r <= 32'h0; mie_r <= 32'h0; mtvec_r <= 32'h0; mcinh_r <= 32'h0;
      mscratch_r <= 32'h0; mepc_r <= 32'h0; mcause_r <= 32'h0; mip_r <= 32'h0;
      flush_r <= 1'b0; trap_taken_r <= 1'b0;
      for (int i = 0; i < NUM_NC_REGIONS; i++) begin
        nc_base_r[i]  <= 32'h0;
        nc_limit_r[i] <= 32'h0;
      end
    end else begin
      mip_r <= {20'h0, ext_itr, 3'h0, timer_itr, 3'h0, soft_itr, 3'h0};
      if (trap_s) begin
        trap_taken_r <= 1'b1;
        mstatus_r    <= {24'h0, mstatus_r[3], 7'h00};
        mepc_r       <= {current_core_pc[31:2], 2'b00};
        mcause_r     <= {irq_s, code_s};
      end else begin
        if (m_ret) begin
          trap_taken_r <= 1'b0;
          mstatus_r    <= {24'h0, 1'b1, 3'h0, mstatus_r[7], 3'h0};
        end else if (wr_s && bus.address == CSR_MSTATUS) begin
          mstatus_r <= wval_s & MSTATUS_WMASK;
        end
        if (wr_s && bus.address == CSR_MEPC)   mepc_r   <= {wval_s[31:2], 2'b00};
        if (wr_s && bus.address == CSR_MCAUSE) mcause_r <= wval_s;
      end
      if (wr_s && bus.address == CSR_MIE)           mie_r      <= wval_s & MIE_WMASK;
      if (wr_s && bus.address == CSR_MTVEC)         mtvec_r    <= mtvec_wr_s;
      if (wr_s && bus.address == CSR_MCOUNTINHIBIT) mcinh_r    <= wval_s & MCINH_WMASK;
      if (wr_s && bus.address == CSR_MSCRATCH)      mscratch_r <= wval_s;
      if (flush_r) begin
        flush_r <= 1'b0;
      end else if (wr_s && bus.address == CSR_FLUSH) begin
        flush_r <= wval_s[0];
      end
      for (int i = 0; i < NUM_NC_REGIONS; i++) begin
        if (wr_s && bus.address == nc_addr(i, 1'b0)) nc_base_r[i]  <= wval_s;
        if (wr_s && bus.address == nc_addr(i, 1'b1)) nc_limit_r[i] <= wval_s;
      end
    end
  end

  holy_csr_counter64 u_mcycle (
    .clk(clk), .rst_n(rst_n), .inc(COUNTERS_EN != 0), .inhibit(mcinh_r[0]),
    .wr_lo(wr_s && bus.address == CSR_MCYCLE), .wr_hi(wr_s && bus.address == CSR_MCYCLEH),
    .wdata(wval_s), .value(mcycle_s)
  );

  holy_csr_counter64 u_minstret (
    .clk(clk), .rst_n(rst_n), .inc(instr_retired && (COUNTERS_EN != 0)), .inhibit(mcinh_r[2]),
    .wr_lo(wr_s && bus.address == CSR_MINSTRET), .wr_hi(wr_s && bus.address == CSR_MINSTRETH),
    .wdata(wval_s), .value(minstret_s)
  );

  // Flatten region registers onto the output buses.
  always_comb begin
    nc_base  = '0;
    nc_limit = '0;
    for (int i = 0; i < NUM_NC_REGIONS; i++) begin
      nc_base[32*i +: 32]  = nc_base_r[i];
      nc_limit[32*i +: 32] = nc_limit_r[i];
    end
  end

  assign bus.read_data      = rdata_s;
  assign bus.illegal_access = illegal_s;
  assign flush_cache_flag   = flush_r;
  assign trap               = trap_s;
  assign trap_target        = {mtvec_r[31:2], 2'b00} + vec_off_s;
  assign csr_mepc           = mepc_r;

endmodule

// File: tb/tb_holy_csr_unit.sv
// Scenario bench for holy_csr_unit: expected values are queued when stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_holy_csr_unit;
  import holy_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] current_core_pc = 32'h0;
  logic        instr_retired = 1'b0, timer_itr = 1'b0, soft_itr = 1'b0, ext_itr = 1'b0;
  logic        m_ret = 1'b0, exception = 1'b0;
  logic [30:0] exception_cause = 31'h0;
  logic        flush_cache_flag, trap;
  logic [63:0] nc_base, nc_limit;
  logic [31:0] trap_target, csr_mepc;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp_v;
  bit          ok;

  holy_csr_if bus_if ();

  holy_csr_unit #(.NUM_NC_REGIONS(2), .VECTORED_EN(1), .COUNTERS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .current_core_pc(current_core_pc),
    .instr_retired(instr_retired), .timer_itr(timer_itr), .soft_itr(soft_itr),
    .ext_itr(ext_itr), .m_ret(m_ret), .exception(exception),
    .exception_cause(exception_cause), .flush_cache_flag(flush_cache_flag),
    .nc_base(nc_base), .nc_limit(nc_limit), .trap(trap), .trap_target(trap_target),
    .csr_mepc(csr_mepc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.read_data;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [2:0] op);
    bus_if.address = a; bus_if.write_data = d; bus_if.f3 = op; bus_if.write_enable = 1'b1;
    tick();
    bus_if.write_enable = 1'b0;
  endtask

  task automatic wait_trap(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (trap === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL rst_mstatus got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MTVEC, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL rst_mtvec got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MHARTID, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL rst_mhartid got=%h exp=%h", got, exp_v); else passes++;
    exp_v = exp_q.pop_front(); checks++;
    if (csr_mepc !== exp_v) $display("FAIL rst_mepc got=%h exp=%h", csr_mepc, exp_v); else passes++;
    checks++;
    if ({trap, flush_cache_flag, bus_if.illegal_access} !== 3'b000)
      $display("FAIL rst_flags got=%b exp=000", {trap, flush_cache_flag, bus_if.illegal_access});
    else passes++;
    checks++;
    if ({nc_base, nc_limit} !== 128'h0) $display("FAIL rst_nc got=%h exp=0", {nc_base, nc_limit});
    else passes++;
  endtask

  task automatic test_vectored_irq();
    wr(CSR_MTVEC, 32'h1001, 3'b001);
    wr(CSR_MIE, 32'h800, 3'b001);
    wr(CSR_MSTATUS, 32'h8, 3'b001);
    current_core_pc = 32'h0000_0402;
    exp_q.push_back(32'h102C); exp_q.push_back(32'h8000_000B);
    exp_q.push_back(32'h80);   exp_q.push_back(32'h400);
    ext_itr = 1'b1;
    tick();
    wait_trap(ok); checks++;
    if (!ok) $display("FAIL vec_trap got=0 exp=1"); else passes++;
    exp_v = exp_q.pop_front(); checks++;
    if (trap_target !== exp_v) $display("FAIL vec_target got=%h exp=%h", trap_target, exp_v); else passes++;
    ext_itr = 1'b0;
    tick();
    rd(CSR_MCAUSE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL vec_mcause got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL vec_mstatus got=%h exp=%h", got, exp_v); else passes++;
    exp_v = exp_q.pop_front(); checks++;
    if (csr_mepc !== exp_v) $display("FAIL vec_mepc got=%h exp=%h", csr_mepc, exp_v); else passes++;
    m_ret = 1'b1; exp_q.push_back(32'h88);
    tick();
    m_ret = 1'b0;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mret_mstatus got=%h exp=%h", got, exp_v); else passes++;
  endtask

  task automatic test_priority();
    wr(CSR_MIE, 32'h888, 3'b001);
    exp_q.push_back(32'h8000_000B);
    ext_itr = 1'b1; soft_itr = 1'b1; timer_itr = 1'b1;
    tick();
    wait_trap(ok); checks++;
    if (!ok) $display("FAIL prio_trap got=0 exp=1"); else passes++;
    tick();
    rd(CSR_MCAUSE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL prio_ext got=%h exp=%h", got, exp_v); else passes++;
    exp_q.push_back(32'h100C); exp_q.push_back(32'h8000_0003);
    ext_itr = 1'b0; m_ret = 1'b1;
    tick();
    m_ret = 1'b0;
    wait_trap(ok);
    exp_v = exp_q.pop_front(); checks++;
    if (!ok || trap_target !== exp_v) $display("FAIL prio_soft_target got=%h exp=%h", trap_target, exp_v);
    else passes++;
    tick();
    rd(CSR_MCAUSE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL prio_soft got=%h exp=%h", got, exp_v); else passes++;
    soft_itr = 1'b0; timer_itr = 1'b0;
    tick();
    m_ret = 1'b1;
    tick();
    m_ret = 1'b0;
    wr(CSR_MIE, 32'h0, 3'b001);
  endtask

  task automatic test_exception();
    exp_q.push_back(32'h2000);
    wr(CSR_MTVEC, 32'h2003, 3'b001);
    rd(CSR_MTVEC, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mtvec_warl got=%h exp=%h", got, exp_v); else passes++;
    wr(CSR_MSTATUS, 32'h0, 3'b001);
    wr(CSR_MIE, 32'h8, 3'b001);
    soft_itr = 1'b1;
    tick();
    #1; checks++;
    if (trap !== 1'b0) $display("FAIL exc_masked got=%b exp=0", trap); else passes++;
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2); exp_q.push_back(32'h1234); exp_q.push_back(32'h0);
    exception = 1'b1; exception_cause = 31'd2; current_core_pc = 32'h1237;
    #1; exp_v = exp_q.pop_front(); checks++;
    if (trap !== 1'b1 || trap_target !== exp_v)
      $display("FAIL exc_target got=%b/%h exp=1/%h", trap, trap_target, exp_v);
    else passes++;
    tick();
    exception = 1'b0;
    rd(CSR_MCAUSE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL exc_mcause got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MEPC, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL exc_mepc got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL exc_mstatus got=%h exp=%h", got, exp_v); else passes++;
    m_ret = 1'b1; soft_itr = 1'b0;
    tick();
    m_ret = 1'b0;
    wr(CSR_MIE, 32'h0, 3'b001);
  endtask

  task automatic test_counters();
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    wr(CSR_MCYCLEH, 32'h0, 3'b001);
    wr(CSR_MCYCLE, 32'hFFFF_FFFF, 3'b001);
    tick();
    rd(CSR_MCYCLE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mcycle_wrap got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MCYCLEH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mcycle_carry got=%h exp=%h", got, exp_v); else passes++;
    wr(CSR_MCOUNTINHIBIT, 32'h1, 3'b001);
    for (int i = 0; i < 4; i++) tick();
    rd(CSR_MCYCLE, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mcycle_inhibit got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MCYCLEH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mcycleh_inhibit got=%h exp=%h", got, exp_v); else passes++;
    exp_q.push_back(32'd8); exp_q.push_back(32'd8);
    wr(CSR_MINSTRET, 32'd5, 3'b001);
    instr_retired = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    instr_retired = 1'b0;
    rd(CSR_MINSTRET, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL minstret_count got=%h exp=%h", got, exp_v); else passes++;
    wr(CSR_MCOUNTINHIBIT, 32'h5, 3'b001);
    instr_retired = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    instr_retired = 1'b0;
    rd(CSR_MINSTRET, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL minstret_inhibit got=%h exp=%h", got, exp_v); else passes++;
    wr(CSR_MCOUNTINHIBIT, 32'h0, 3'b001);
  endtask

  task automatic test_nc_regions();
    exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h9000_0000);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h8000_0000);
    wr(12'h7C3, 32'h8000_0000, 3'b001);
    wr(12'h7C4, 32'h9000_0000, 3'b001);
    exp_v = exp_q.pop_front(); checks++;
    if (nc_base[63:32] !== exp_v) $display("FAIL nc_base1 got=%h exp=%h", nc_base[63:32], exp_v); else passes++;
    exp_v = exp_q.pop_front(); checks++;
    if (nc_limit[63:32] !== exp_v) $display("FAIL nc_limit1 got=%h exp=%h", nc_limit[63:32], exp_v); else passes++;
    bus_if.address = 12'h7C5; bus_if.write_data = 32'hDEAD_BEEF; bus_if.f3 = 3'b001;
    bus_if.write_enable = 1'b1;
    #1; checks++;
    if (bus_if.illegal_access !== 1'b1) $display("FAIL illegal_7c5 got=%b exp=1", bus_if.illegal_access); else passes++;
    tick();
    bus_if.address = 12'hF11;
    #1; checks++;
    if (bus_if.illegal_access !== 1'b1) $display("FAIL illegal_ro got=%b exp=1", bus_if.illegal_access); else passes++;
    tick();
    bus_if.write_enable = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (nc_base[31:0] !== exp_v) $display("FAIL nc_base0_kept got=%h exp=%h", nc_base[31:0], exp_v); else passes++;
    exp_v = exp_q.pop_front(); checks++;
    if (nc_base[63:32] !== exp_v) $display("FAIL nc_base1_kept got=%h exp=%h", nc_base[63:32], exp_v); else passes++;
    exp_q.push_back(32'hFF); exp_q.push_back(32'hC3);
    wr(CSR_MSCRATCH, 32'hF0, 3'b001);
    wr(CSR_MSCRATCH, 32'h0F, 3'b010);
    rd(CSR_MSCRATCH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL csr_set got=%h exp=%h", got, exp_v); else passes++;
    wr(CSR_MSCRATCH, 32'h3C, 3'b111);
    rd(CSR_MSCRATCH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL csr_clear got=%h exp=%h", got, exp_v); else passes++;
  endtask

  task automatic test_flush();
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    wr(CSR_FLUSH, 32'h1, 3'b001);
    #1; exp_v = exp_q.pop_front(); checks++;
    if ({31'h0, flush_cache_flag} !== exp_v) $display("FAIL flush_hi got=%b exp=%h", flush_cache_flag, exp_v); else passes++;
    tick();
    #1; exp_v = exp_q.pop_front(); checks++;
    if ({31'h0, flush_cache_flag} !== exp_v) $display("FAIL flush_lo got=%b exp=%h", flush_cache_flag, exp_v); else passes++;
    rd(CSR_FLUSH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL flush_read got=%h exp=%h", got, exp_v); else passes++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h1111); exp_q.push_back(32'h0); exp_q.push_back(32'h80);
    wr(CSR_MSCRATCH, 32'h1111, 3'b001);
    exception = 1'b1; exception_cause = 31'd5;
    wr(CSR_MSCRATCH, 32'h2222, 3'b001);
    exception = 1'b0;
    rd(CSR_MSCRATCH, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL trap_drops_write got=%h exp=%h", got, exp_v); else passes++;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL trap_mstatus got=%h exp=%h", got, exp_v); else passes++;
    m_ret = 1'b1;
    wr(CSR_MSTATUS, 32'h88, 3'b001);
    m_ret = 1'b0;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL mret_beats_write got=%h exp=%h", got, exp_v); else passes++;
    exp_q.push_back(32'h0);
    exception = 1'b1; m_ret = 1'b1;
    tick();
    m_ret = 1'b0;
    #1; checks++;
    if (trap !== 1'b0) $display("FAIL trap_beats_mret got=%b exp=0", trap); else passes++;
    rd(CSR_MSTATUS, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL trap_mret_mstatus got=%h exp=%h", got, exp_v); else passes++;
    exception = 1'b0; m_ret = 1'b1;
    tick();
    m_ret = 1'b0;
  endtask

  task automatic test_reset_mid_trap();
    exp_q.push_back(32'h0);
    exception = 1'b1; exception_cause = 31'd1; current_core_pc = 32'h88;
    tick();
    #1; checks++;
    if (trap !== 1'b0) $display("FAIL midtrap_taken got=%b exp=0", trap); else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1; checks++;
    if (trap !== 1'b1) $display("FAIL midtrap_cleared got=%b exp=1", trap); else passes++;
    rd(CSR_MEPC, got); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) $display("FAIL midtrap_mepc got=%h exp=%h", got, exp_v); else passes++;
    exception = 1'b0;
    tick();
  endtask

  initial begin
    bus_if.f3 = 3'b000; bus_if.write_data = 32'h0; bus_if.write_enable = 1'b0;
    bus_if.address = CSR_MSTATUS;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_vectored_irq();
    test_priority();
    test_exception();
    test_counters();
    test_nc_regions();
    test_flush();
    test_back_to_back();
    test_reset_mid_trap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
